// File: rtl/pmu_pkg.sv
// Shared types and helpers for the dTLB PMU sampler: sample record, FSM states,
// and the saturating delta narrowing used when building a sample.
package pmu_pkg;

  localparam int CNT_W    = 64;
  localparam int DELTA_W  = 32;
  localparam int PERIOD_W = 16;
  localparam int SEQ_W    = 8;

  typedef struct packed {
    logic [DELTA_W-1:0] hit;
    logic [DELTA_W-1:0] miss;
    logic [DELTA_W-1:0] pref;
    logic [SEQ_W-1:0]   seq;
  } pmu_sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pmu_state_t;

  // Any set bit above the delta width means the window overflowed the field.
  function automatic logic [DELTA_W-1:0] sat_trunc(input logic [CNT_W-1:0] val);
    if (|val[CNT_W-1:DELTA_W]) begin
      return {DELTA_W{1'b1}};
    end
    return val[DELTA_W-1:0];
  endfunction

endpackage

// File: rtl/pmu_sample_fifo.sv
// Small synchronous FIFO of PMU samples; a push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module pmu_sample_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  pmu_pkg::pmu_sample_t push_data,
  input  logic                 pop,
  output pmu_pkg::pmu_sample_t pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          level
);
  import pmu_pkg::*;

  pmu_sample_t     mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is cleared on reset so the head reads zero while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign level    = count_reg;

endmodule

// File: rtl/pmu_sampler.sv
// Periodically snapshots the dTLB hit/miss/prefetch counters and streams the
// saturated per-interval deltas, tagged with a sequence number, out of a FIFO.
module pmu_sampler #(
  parameter int CNT_W      = pmu_pkg::CNT_W,
  parameter int DELTA_W    = pmu_pkg::DELTA_W,
  parameter int PERIOD_W   = pmu_pkg::PERIOD_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [PERIOD_W-1:0]           period,
  input  logic [CNT_W-1:0]              hit_cnt,
  input  logic [CNT_W-1:0]              miss_cnt,
  input  logic [CNT_W-1:0]              pref_cnt,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [DELTA_W-1:0]            sample_hit,
  output logic [DELTA_W-1:0]            sample_miss,
  output logic [DELTA_W-1:0]            sample_pref,
  output logic [7:0]                    sample_seq,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import pmu_pkg::*;

  pmu_state_t          state_reg, state_next;
  logic [PERIOD_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0]    last_hit_reg, last_miss_reg, last_pref_reg;
  logic [7:0]          seq_reg;
  logic [15:0]         drop_reg;

  logic        run_ok;
  logic        snap;
  logic        capture;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  pmu_sample_t push_data;
  pmu_sample_t head;

  assign run_ok = enable && (period != '0);

  // While idle the baseline tracks the live counters, so a new window always
  // starts from the values seen on the cycle before the first RUN cycle.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    snap       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        snap       = 1'b1;
        timer_next = period - PERIOD_W'(1);
        if (run_ok) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!run_ok) begin
          state_next = IDLE;
        end else if (timer_reg == '0) begin
          capture    = 1'b1;
          timer_next = period - PERIOD_W'(1);
        end else begin
          timer_next = timer_reg - PERIOD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      last_hit_reg  <= '0;
      last_miss_reg <= '0;
      last_pref_reg <= '0;
      seq_reg       <= '0;
      drop_reg      <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (snap || capture) begin
        last_hit_reg  <= hit_cnt;
        last_miss_reg <= miss_cnt;
        last_pref_reg <= pref_cnt;
      end
      if (capture) begin
        seq_reg <= seq_reg + 8'd1;
      end
      // A capture that finds the FIFO full with no pop is lost but still consumes a seq.
      if (capture && fifo_full && !pop && (drop_reg != 16'hFFFF)) begin
        drop_reg <= drop_reg + 16'd1;
      end
    end
  end

  // Modular subtraction makes a counter wrap inside the window come out small.
  always_comb begin
    push_data      = '0;
    push_data.hit  = sat_trunc(hit_cnt  - last_hit_reg);
    push_data.miss = sat_trunc(miss_cnt - last_miss_reg);
    push_data.pref = sat_trunc(pref_cnt - last_pref_reg);
    push_data.seq  = seq_reg;
  end

  assign pop = !fifo_empty && sample_ready;

  pmu_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign sample_valid = !fifo_empty;
  assign sample_hit   = head.hit;
  assign sample_miss  = head.miss;
  assign sample_pref  = head.pref;
  assign sample_seq   = head.seq;
  assign drop_cnt     = drop_reg;

endmodule
